// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Bit positions in the 2-bit request/grant vectors; also the last_gnt encoding.
    localparam bit GNT_IF = 1'b0;
    localparam bit GNT_D  = 1'b1;

    function automatic logic [31:0] fetch_word_sel(input logic [63:0] line, input logic upper);
        return upper ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on conflict, or fixed priority to the data port.
module mem_port_arbiter_rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    logic last_gnt_q;
    logic last_gnt_d;

    always_comb begin
        gnt = 2'b00;
        if (nrst) begin
            if (req[GNT_IF] && req[GNT_D]) begin
                // Reset leaves last_gnt at IF, so data wins the first conflict.
                if (fixed_prio || (last_gnt_q == GNT_IF)) begin
                    gnt[GNT_D] = 1'b1;
                end else begin
                    gnt[GNT_IF] = 1'b1;
                end
            end else begin
                gnt = req;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt[GNT_D]) begin
            last_gnt_d = GNT_D;
        end else if (gnt[GNT_IF]) begin
            last_gnt_d = GNT_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            last_gnt_q <= GNT_IF;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 64-bit memory between instruction-fetch and data ports,
// with registered one-cycle read responses and a saturating conflict counter.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 29,
    parameter bit          DATA_PRIO  = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [63:0]           d_wdata,
    input  logic [7:0]            d_wmask,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [63:0]           d_rdata,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [63:0]           mem_wdata,
    output logic [7:0]            mem_wmask,
    input  logic [63:0]           mem_rdata,
    output logic [CNT_W-1:0]      conflict_cnt
);

    logic [1:0] req;
    logic [1:0] gnt;

    logic             if_rvalid_q;
    logic [31:0]      if_rdata_q;
    logic             d_rvalid_q;
    logic [63:0]      d_rdata_q;
    logic [CNT_W-1:0] cnt_q;

    // Byte-offset bits never reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[2:0]};

    always_comb begin
        req         = 2'b00;
        req[GNT_IF] = if_req;
        req[GNT_D]  = d_req;
    end

    mem_port_arbiter_rr_arb2 u_arb (
        .clk        (clk),
        .nrst       (nrst),
        .req        (req),
        .fixed_prio (DATA_PRIO),
        .gnt        (gnt)
    );

    assign if_gnt = gnt[GNT_IF];
    assign d_gnt  = gnt[GNT_D];

    always_comb begin
        mem_addr  = '0;
        mem_wr_en = d_gnt & d_we;
        mem_wdata = '0;
        mem_wmask = '0;
        if (if_gnt) begin
            mem_addr = if_addr[MEM_ADDR_W+2:3];
        end else if (d_gnt) begin
            mem_addr  = d_addr[MEM_ADDR_W+2:3];
            mem_wdata = d_wdata;
            mem_wmask = d_wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            cnt_q       <= '0;
        end else begin
            if_rvalid_q <= if_gnt;
            d_rvalid_q  <= d_gnt;
            if (if_gnt) begin
                if_rdata_q <= fetch_word_sel(mem_rdata, if_addr[2]);
            end
            if (d_gnt && !d_we) begin
                d_rdata_q <= mem_rdata;
            end
            if (if_req && d_req && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // A response due in a reset cycle is suppressed rather than presented.
    assign if_rvalid    = if_rvalid_q & nrst;
    assign d_rvalid     = d_rvalid_q & nrst;
    assign if_rdata     = if_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants and responses; a separate
// monitor checks each response against the queued prediction.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 29;
    localparam int unsigned CMAX = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: round-robin, 16-bit counter
    logic          nrst, if_req, if_gnt, if_rvalid;
    logic [31:0]   if_addr, if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [31:0]   d_addr;
    logic [63:0]   d_wdata, d_rdata;
    logic [7:0]    d_wmask;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [63:0]   mem_wdata, mem_rdata;
    logic [7:0]    mem_wmask;
    logic [15:0]   conflict_cnt;

    mem_port_arbiter #(.MEM_ADDR_W(AW), .DATA_PRIO(1'b0), .CNT_W(16)) dut (
        .clk(clk), .nrst(nrst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    // Second DUT: data priority, 2-bit counter
    logic          p_nrst, p_if_req, p_if_gnt, p_if_rvalid;
    logic [31:0]   p_if_addr, p_if_rdata;
    logic          p_d_req, p_d_we, p_d_gnt, p_d_rvalid;
    logic [31:0]   p_d_addr;
    logic [63:0]   p_d_wdata, p_d_rdata;
    logic [7:0]    p_d_wmask;
    logic [AW-1:0] p_mem_addr;
    logic          p_mem_wr_en;
    logic [63:0]   p_mem_wdata, p_mem_rdata;
    logic [7:0]    p_mem_wmask;
    logic [1:0]    p_conflict_cnt;

    mem_port_arbiter #(.MEM_ADDR_W(AW), .DATA_PRIO(1'b1), .CNT_W(2)) dut_prio (
        .clk(clk), .nrst(p_nrst),
        .if_req(p_if_req), .if_addr(p_if_addr), .if_gnt(p_if_gnt), .if_rvalid(p_if_rvalid),
        .if_rdata(p_if_rdata),
        .d_req(p_d_req), .d_we(p_d_we), .d_addr(p_d_addr), .d_wdata(p_d_wdata),
        .d_wmask(p_d_wmask), .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata),
        .mem_addr(p_mem_addr), .mem_wr_en(p_mem_wr_en), .mem_wdata(p_mem_wdata),
        .mem_wmask(p_mem_wmask), .mem_rdata(p_mem_rdata), .conflict_cnt(p_conflict_cnt)
    );

    assign p_mem_rdata = {3'b000, p_mem_addr, 3'b111, p_mem_addr};

    // Memory seen by the main DUT: 64 lines, indexed by byte address bits [8:3]
    logic [63:0] mem [64];
    assign mem_rdata = mem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (mem_wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (mem_wmask[b]) mem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    int n_cmp;
    int n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [63:0] ref_mem [64];
    bit          m_last_d;
    int unsigned m_cnt;
    logic [63:0] m_dheld;
    logic [31:0] q_if [$];
    logic [63:0] q_d  [$];
    bit          if_taken, d_taken;
    bit          eg_if, eg_d;
    logic [63:0] m_line;
    logic [31:0] m_exp_addr;

    // Prediction: who wins this cycle, what the memory should see, what comes back next cycle
    always @(negedge clk) begin
        eg_if = 1'b0;
        eg_d  = 1'b0;
        if (nrst) begin
            if (if_req && d_req) begin
                if (m_last_d) eg_if = 1'b1;
                else          eg_d  = 1'b1;
            end else begin
                eg_if = if_req;
                eg_d  = d_req;
            end
        end
        check("if_gnt", {63'd0, if_gnt}, {63'd0, eg_if});
        check("d_gnt", {63'd0, d_gnt}, {63'd0, eg_d});
        check("mem_wr_en", {63'd0, mem_wr_en}, {63'd0, eg_d && d_we});
        m_exp_addr = eg_if ? (if_addr >> 3) : (eg_d ? (d_addr >> 3) : 32'd0);
        check("mem_addr", {35'd0, mem_addr}, {32'd0, m_exp_addr});
        check("mem_wdata", mem_wdata, eg_d ? d_wdata : 64'd0);
        check("mem_wmask", {56'd0, mem_wmask}, {56'd0, (eg_d ? d_wmask : 8'd0)});
        check("conflict_cnt", {48'd0, conflict_cnt}, 64'(m_cnt));
        if (eg_if) begin
            m_line = ref_mem[if_addr[8:3]];
            q_if.push_back(if_addr[2] ? m_line[63:32] : m_line[31:0]);
            m_last_d = 1'b0;
        end
        if (eg_d) begin
            if (d_we) begin
                q_d.push_back(m_dheld);
                for (int b = 0; b < 8; b++) begin
                    if (d_wmask[b]) ref_mem[d_addr[8:3]][b*8 +: 8] = d_wdata[b*8 +: 8];
                end
            end else begin
                m_dheld = ref_mem[d_addr[8:3]];
                q_d.push_back(m_dheld);
            end
            m_last_d = 1'b1;
        end
        if (!nrst) begin
            m_cnt    = 0;
            m_last_d = 1'b0;
            m_dheld  = '0;
        end else if (if_req && d_req && m_cnt < CMAX) begin
            m_cnt++;
        end
        if_taken = eg_if;
        d_taken  = eg_d;
    end

    // Response monitor
    bit          nrst_prev;
    bit          exp_v;
    logic [63:0] exp_w;
    always @(posedge clk) begin
        #3;
        if (!nrst) begin
            q_if.delete();
            q_d.delete();
        end
        exp_v = (q_if.size() != 0);
        check("if_rvalid", {63'd0, if_rvalid}, {63'd0, exp_v});
        if (exp_v) begin
            exp_w = {32'd0, q_if.pop_front()};
            if (if_rvalid) check("if_rdata", {32'd0, if_rdata}, exp_w);
        end
        exp_v = (q_d.size() != 0);
        check("d_rvalid", {63'd0, d_rvalid}, {63'd0, exp_v});
        if (exp_v) begin
            exp_w = q_d.pop_front();
            if (d_rvalid) check("d_rdata", d_rdata, exp_w);
        end
        if (!nrst_prev) begin
            check("if_rdata after reset", {32'd0, if_rdata}, 64'd0);
            check("d_rdata after reset", d_rdata, 64'd0);
        end
        nrst_prev = nrst;
    end

    int          bad;
    logic [63:0] v;

    initial begin
        n_cmp = 0; n_err = 0;
        m_last_d = 1'b0; m_cnt = 0; m_dheld = '0; nrst_prev = 1'b1;
        if_taken = 1'b0; d_taken = 1'b0;
        nrst = 1'b0; if_req = 1'b1; if_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20;
        d_wdata = 64'hFFFF_FFFF_FFFF_FFFF; d_wmask = 8'hFF;
        p_nrst = 1'b0; p_if_req = 1'b1; p_if_addr = 32'h100;
        p_d_req = 1'b1; p_d_we = 1'b0; p_d_addr = 32'h208; p_d_wdata = '0; p_d_wmask = '0;
        for (int i = 0; i < 64; i++) begin
            v = {$urandom, $urandom};
            mem[i] <= v;
            ref_mem[i] = v;
        end
        mem[0] <= 64'h00300093_00000013;
        ref_mem[0] = 64'h00300093_00000013;
        mem[4] <= 64'd0;
        ref_mem[4] = 64'd0;

        // Reset with both ports requesting a store
        repeat (2) @(posedge clk);
        #2;
        check("reset gnts", {62'd0, if_gnt, d_gnt}, 64'd0);
        check("reset mem_wr_en", {63'd0, mem_wr_en}, 64'd0);
        check("reset conflict_cnt", {48'd0, conflict_cnt}, 64'd0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem untouched in reset", 64'(bad), 64'd0);

        // Fetch of the upper word of line 0
        @(posedge clk); #1;
        nrst = 1'b1; if_req = 1'b1; if_addr = 32'h4; d_req = 1'b0; d_we = 1'b0;
        #1;
        check("fetch gnt same cycle", {63'd0, if_gnt}, 64'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20;
        d_wdata = 64'hDEADBEEF_CAFEF00D; d_wmask = 8'h0F;
        #1;
        check("fetch rvalid", {63'd0, if_rvalid}, 64'd1);
        check("fetch word", {32'd0, if_rdata}, 64'h00300093);
        check("store gnt", {63'd0, d_gnt}, 64'd1);
        check("store wr_en", {63'd0, mem_wr_en}, 64'd1);

        // Masked store then load-back
        @(posedge clk); #1;
        d_we = 1'b0;
        #1;
        check("store rvalid", {63'd0, d_rvalid}, 64'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        #1;
        check("load rvalid", {63'd0, d_rvalid}, 64'd1);
        check("load data", d_rdata, 64'h00000000_CAFEF00D);
        @(posedge clk); #1;
        check("rvalid one cycle", {63'd0, d_rvalid}, 64'd0);
        check("rdata held", d_rdata, 64'h00000000_CAFEF00D);

        // Round-robin conflict from reset: D, IF, D, IF
        nrst = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = $urandom; d_addr = $urandom;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr grant", {62'd0, if_gnt, d_gnt}, (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k > 0) check("rr rvalid", {62'd0, if_rvalid, d_rvalid},
                             (k % 2 == 1) ? 64'd1 : 64'd2);
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        #1;
        check("rr conflict_cnt", {48'd0, conflict_cnt}, 64'd4);
        check("rr last rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd2);

        // Randomised traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            nrst = ($urandom_range(0, 63) != 0);
            if (!if_req || if_taken) begin
                if_req  = ($urandom_range(0, 99) < 55);
                if_addr = $urandom;
            end
            if (!d_req || d_taken) begin
                d_req   = ($urandom_range(0, 99) < 55);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom;
                d_wdata = {$urandom, $urandom};
                d_wmask = 8'($urandom);
            end
        end
        @(posedge clk); #1;
        nrst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Data-priority instance: data always wins, counter saturates at 3
        p_nrst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("prio d_gnt", {63'd0, p_d_gnt}, 64'd1);
            check("prio if_gnt", {63'd0, p_if_gnt}, 64'd0);
            @(posedge clk); #1;
        end
        p_d_req = 1'b0;
        #1;
        check("prio if_gnt when d idle", {63'd0, p_if_gnt}, 64'd1);
        check("prio cnt saturated", {62'd0, p_conflict_cnt}, 64'd3);
        @(posedge clk); #1;
        p_if_req = 1'b0; p_d_req = 1'b1; p_d_we = 1'b0;
        #1;
        check("prio fetch rvalid", {63'd0, p_if_rvalid}, 64'd1);
        check("prio fetch word", {32'd0, p_if_rdata}, 64'hE000_0020);
        check("prio load gnt", {63'd0, p_d_gnt}, 64'd1);
        @(posedge clk); #1;
        p_nrst = 1'b0; p_d_req = 1'b0;
        #1;
        check("rvalid dropped by reset", {63'd0, p_d_rvalid}, 64'd0);
        @(posedge clk); #1;
        p_nrst = 1'b1;
        #1;
        check("prio cnt after reset", {62'd0, p_conflict_cnt}, 64'd0);
        check("prio d_rdata after reset", p_d_rdata, 64'd0);
        check("prio d_rvalid after reset", {63'd0, p_d_rvalid}, 64'd0);

        @(posedge clk); #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
